multi_channel_packet_engine: RTL and testbench



---
 rtl/multi_channel_packet_engine_pkg.sv | 30 +++
 rtl/multi_channel_packet_engine_rr_arbiter.sv | 33 +++
 rtl/multi_channel_packet_engine.sv | 135 +++++++++++++
 tb/tb_multi_channel_packet_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_packet_engine_pkg.sv
// Shared types and constants for multi_channel_packet_engine.
// crc8_word: CRC-8 (poly 0x07, init 0, no reflection) over the low `width` bits, MSB first.
package pkt_engine_pkg;

  typedef enum logic [2:0] {IDLE, REQUEST, LOAD, HEADER, PAYLOAD, CRC, DONE} state_t;

  localparam logic [7:0] HDR_MARKER = 8'hA5;
  localparam logic [7:0] CRC8_POLY  = 8'h07;
  localparam int unsigned CRC_MAX_W = 256;

  function automatic logic [7:0] crc8_word(input logic [CRC_MAX_W-1:0] data,
                                           input int unsigned width);
    logic [7:0]           crc;
    logic [CRC_MAX_W-1:0] d;
    logic                 fb;
    crc = '0;
    fb  = 1'b0;
    // Left-align the word so its MSB sits at the top of the shift register.
    d   = data << (CRC_MAX_W - width);
    for (int unsigned i = 0; i < CRC_MAX_W; i++) begin
      if (i < width) begin
        fb  = crc[7] ^ d[CRC_MAX_W-1];
        crc = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        d   = d << 1;
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/multi_channel_packet_engine_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  always_comb begin
    int unsigned sum;
    logic [IDX_W-1:0] cand;
    sum   = 0;
    cand  = '0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      cand = IDX_W'(sum);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_channel_packet_engine.sv
// Round-robin request/load engine emitting header+payload packets on valid/ready.
// Define PKT_CRC_EN to append a CRC-8 word over the payload.
module multi_channel_packet_engine
  import pkt_engine_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int SHIFT   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_req,
  output logic [NUM_CH-1:0] data_request,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state;
  logic [IDX_W-1:0]    ch_id;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    ch_next;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   payload;
  logic [NUM_CH-1:0]   arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_found;
`ifdef PKT_CRC_EN
  logic [7:0]          crc_q;
`endif

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (ch_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  assign ch_next = (ch_id == IDX_W'(NUM_CH - 1)) ? '0 : ch_id + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      ch_id        <= '0;
      cnt          <= '0;
      payload      <= '0;
      data_request <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      timeout_err  <= 1'b0;
`ifdef PKT_CRC_EN
      crc_q        <= '0;
`endif
    end else begin
      data_request <= '0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: if (arb_found) begin
          ch_id        <= arb_idx;
          data_request <= arb_grant;
          state        <= REQUEST;
        end
        REQUEST: begin
          cnt   <= '0;
          state <= LOAD;
        end
        // cnt holds the index of the current LOAD cycle; the last one still accepts data.
        LOAD: if (data_valid) begin
          payload   <= data_in << SHIFT;
`ifdef PKT_CRC_EN
          crc_q     <= crc8_word(CRC_MAX_W'(DATA_W'(data_in << SHIFT)), DATA_W);
`endif
          out_data  <= DATA_W'({HDR_MARKER, 8'(ch_id)});
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          state     <= HEADER;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_err <= 1'b1;
          rr_ptr      <= ch_next;
          state       <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        HEADER: if (out_ready) begin
          out_data <= payload;
`ifdef PKT_CRC_EN
          out_last <= 1'b0;
`else
          out_last <= 1'b1;
`endif
          state    <= PAYLOAD;
        end
        PAYLOAD: if (out_ready) begin
`ifdef PKT_CRC_EN
          out_data <= DATA_W'(crc_q);
          out_last <= 1'b1;
          state    <= CRC;
`else
          out_data  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= DONE;
`endif
        end
`ifdef PKT_CRC_EN
        CRC: if (out_ready) begin
          out_data  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= DONE;
        end
`endif
        DONE: begin
          rr_ptr <= ch_next;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_packet_engine.sv
// Randomized bench for multi_channel_packet_engine against a transaction-level model.
`timescale 1ns/1ps
module tb_multi_channel_packet_engine;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int SHIFT   = 2;
  localparam int TIMEOUT = 15;
  localparam int NO_DATA = 255;

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] data_request;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              timeout_err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned model_ptr = 0;

  always #5 clock = ~clock;

  multi_channel_packet_engine #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ch_req      (ch_req),
    .data_request(data_request),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Rotate the request mask so ptr lands at bit 0, then take the lowest set bit.
  function automatic int unsigned pick_ch(input logic [NUM_CH-1:0] mask, input int unsigned ptr);
    logic [2*NUM_CH-1:0] dbl;
    dbl = {mask, mask} >> ptr;
    for (int i = 0; i < NUM_CH; i++)
      if (dbl[i]) return (ptr + i) % NUM_CH;
    return 0;
  endfunction

  function automatic logic [DATA_W-1:0] ref_payload(input logic [DATA_W-1:0] d);
    logic [63:0] prod;
    prod = 64'(d) * (64'd1 << SHIFT);
    return DATA_W'(prod);
  endfunction

  function automatic logic [7:0] ref_crc8(input logic [DATA_W-1:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int b = DATA_W/8 - 1; b >= 0; b--) begin
      c = c ^ 8'(w >> (8*b));
      repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic run_txn(input logic [NUM_CH-1:0] mask, input int delay, input int ready_pct,
                         input bit stall5, input bit drop_req, input logic [DATA_W-1:0] d);
    int unsigned       exp_ch;
    int                t;
    int unsigned       idx, cyc, n, stalls;
    bit                rdy, prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    logic [DATA_W-1:0] exp_w[$];
    bit                exp_l[$];

    ch_req = mask;
    exp_ch = pick_ch(mask, model_ptr);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (data_request == '0 && t < 20);
    check_eq("grant_latency", t, 1);
    check_eq("grant_onehot", data_request, NUM_CH'(1) << exp_ch);
    check_eq("busy_request", busy, 1);
    if (data_request == '0) return;

    // REQUEST cycle: stray data_valid must be ignored
    if (drop_req) ch_req = '0;
    data_valid = 1'b1;
    data_in    = $urandom;
    @(negedge clock);
    data_valid = 1'b0;
    check_eq("request_pulse_len", data_request, 0);

    for (int k = 0; k < TIMEOUT; k++) begin
      check_eq("no_early_timeout", timeout_err, 0);
      check_eq("busy_load", busy, 1);
      if (k == delay) begin
        data_valid = 1'b1;
        data_in    = d;
      end
      @(negedge clock);
      data_valid = 1'b0;
      data_in    = $urandom;
      if (k == delay) break;
    end

    if (delay >= TIMEOUT) begin
      check_eq("timeout_pulse", timeout_err, 1);
      check_eq("timeout_busy", busy, 0);
      check_eq("timeout_no_valid", out_valid, 0);
      ch_req = '0;
      if (delay == TIMEOUT) begin
        data_valid = 1'b1;
        data_in    = $urandom;
      end
      @(negedge clock);
      data_valid = 1'b0;
      check_eq("timeout_one_cycle", timeout_err, 0);
      check_eq("timeout_idle", busy, 0);
      model_ptr = (exp_ch + 1) % NUM_CH;
      return;
    end

    check_eq("header_latency", out_valid, 1);
    check_eq("no_timeout_on_data", timeout_err, 0);

    exp_w.push_back(DATA_W'({8'hA5, 8'(exp_ch)}));
    exp_l.push_back(1'b0);
    exp_w.push_back(ref_payload(d));
`ifdef PKT_CRC_EN
    exp_l.push_back(1'b0);
    exp_w.push_back(DATA_W'(ref_crc8(ref_payload(d))));
    exp_l.push_back(1'b1);
`else
    exp_l.push_back(1'b1);
`endif
    n = exp_w.size();
    idx = 0;
    cyc = 0;
    stalls = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    while (idx < n && cyc < 200) begin
      if (prev_stall) begin
        check_eq("hold_data", out_data, prev_data);
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_last", out_last, prev_last);
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (stall5 && idx == 1 && stalls < 5) begin
        rdy = 1'b0;
        stalls++;
      end
      out_ready = rdy;
      if (!rdy && $urandom_range(2) == 0) begin
        data_valid = 1'b1;
        data_in    = $urandom;
      end
      if (out_valid && rdy) begin
        check_eq($sformatf("word%0d_data", idx), out_data, exp_w[idx]);
        check_eq($sformatf("word%0d_last", idx), out_last, exp_l[idx]);
        idx++;
      end
      prev_data  = out_data;
      prev_last  = out_last;
      prev_stall = out_valid && !rdy;
      @(negedge clock);
      data_valid = 1'b0;
      cyc++;
    end
    check_eq("packet_words", idx, n);
    if (ready_pct >= 100 && !stall5) check_eq("burst_cycles", cyc, n);
    check_eq("done_valid", out_valid, 0);
    check_eq("done_last", out_last, 0);
    check_eq("done_busy", busy, 1);
    @(negedge clock);
    check_eq("gap_idle", busy, 0);
    model_ptr = (exp_ch + 1) % NUM_CH;
  endtask

  task automatic reset_mid_packet();
    int t;
    ch_req = 4'b1000;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (data_request == '0 && t < 20);
    check_eq("rst_pre_grant", data_request, NUM_CH'(1) << pick_ch(4'b1000, model_ptr));
    @(negedge clock);
    out_ready  = 1'b0;
    data_valid = 1'b1;
    data_in    = $urandom;
    @(negedge clock);
    data_valid = 1'b0;
    check_eq("rst_in_header", out_valid, 1);
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    ch_req = '0;
    @(negedge clock);
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_last", out_last, 0);
    check_eq("rst_mid_data", out_data, 0);
    check_eq("rst_mid_req", data_request, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_timeout", timeout_err, 0);
    reset = 1'b0;
    model_ptr = 0;
  endtask

  initial begin
    logic [NUM_CH-1:0] m;
    int                dly, r;
    reset      = 1'b1;
    ch_req     = '0;
    data_in    = '0;
    data_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("reset_request", data_request, 0);
    check_eq("reset_valid", out_valid, 0);
    check_eq("reset_last", out_last, 0);
    check_eq("reset_data", out_data, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_timeout", timeout_err, 0);
    reset = 1'b0;
    @(negedge clock);

    // round robin with every channel requesting: 0,1,2,3,0
    repeat (5) run_txn(4'b1111, 0, 100, 1'b0, 1'b0, $urandom);
    // single request on channel 2, data 10
    run_txn(4'b0100, 0, 100, 1'b0, 1'b0, 32'd10);
    // payload bits shifted out are dropped
    run_txn(4'b0100, 0, 100, 1'b0, 1'b0, 32'hC000_0001);
    // five-cycle stall on the payload word, then random backpressure
    run_txn(4'b0011, 2, 100, 1'b1, 1'b0, $urandom);
    run_txn(4'b1111, 1, 50, 1'b0, 1'b0, $urandom);
    // timeout, late data after timeout, then the next channel gets the grant
    run_txn(4'b1111, NO_DATA, 100, 1'b0, 1'b0, $urandom);
    run_txn(4'b1111, TIMEOUT, 100, 1'b0, 1'b0, $urandom);
    run_txn(4'b1111, 0, 100, 1'b0, 1'b0, $urandom);
    // data on the last permitted LOAD cycle is a normal load
    run_txn(4'b1111, TIMEOUT - 1, 100, 1'b0, 1'b0, $urandom);
    // request withdrawn after grant still completes
    run_txn(4'b0110, 3, 70, 1'b0, 1'b1, $urandom);
    reset_mid_packet();
    run_txn(4'b1111, 0, 100, 1'b0, 1'b0, $urandom);

    for (int i = 0; i < 25; i++) begin
      m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      r = $urandom_range(9);
      dly = (r == 0) ? TIMEOUT : (r == 1) ? NO_DATA : $urandom_range(TIMEOUT - 1);
      run_txn(m, dly, $urandom_range(30, 100), 1'b0, 1'($urandom_range(1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
